ndata_to_axi_packed: RTL and testbench
======================================

# ndata_to_axi_packed

Packs a `NUM_ELEMENTS`-wide ndata stream of 8-, 16-, 32- or 64-bit elements into a `64 * NUM_ELEMENTS`-bit AXI4-Stream. The element width is selected at run time. Input beats accumulate into one full AXI word, which is registered and emitted. The block sits between ndata compute pipelines and the AXI write/network path. It is the multi-width successor of the 32/64-bit-only ndata-to-AXI adapter, and adds a registered output and a zero-filled partial flush on `last`.

## Interface
- `NUM_ELEMENTS`, default 8: elements per ndata beat; each element occupies a 64-bit lane on input.
- `AXI_WIDTH`, derived `64 * NUM_ELEMENTS`, not overridable: output data width.
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset; synchronous, active-low.
- `width_sel`  in  2: element width, encoded as 0=8b, 1=16b, 2=32b, 3=64b. Quasi-static.
- `in`  ndata_i.s  `data[NUM_ELEMENTS]` x 64, `keep[NUM_ELEMENTS]`, `last`, `valid`, `ready`: element stream. Only the low W bits of each lane are meaningful.
- `out`  AXI4S.m  `tdata` AXI_WIDTH, `tkeep` AXI_WIDTH/8, `tlast`, `tvalid`, `tready`: packed stream.

## Operation
- W = 8 << sel, and R = 64/W input beats make one output word (R = 8, 4, 2, 1).
- Slot placement: input beat k of a word (k = 0..R-1) occupies bits `[k*NUM_ELEMENTS*W +: NUM_ELEMENTS*W]`.
  - Element i within that beat lands at `k*NUM_ELEMENTS*W + i*W`, filled from `in.data[i][W-1:0]`.
- Keep mapping: `in.keep[i]` drives all W/8 tkeep bits of that element.
  - Keep is not compacted; sparse keep yields sparse tkeep.
- State:
  - Accumulator `acc_data`/`acc_keep`, reset 0.
  - Slot counter `cnt` (3 bits), range 0..R-1.
  - Latched width `sel_q`.
  - Output register (`tdata`/`tkeep`/`tlast`/`tvalid`).
- Width latch: `width_sel` is captured into `sel_q` on the accepted beat where `cnt == 0`. Changes while `cnt != 0` are ignored until the current word is emitted.
- Accept condition: `in.valid && in.ready`. On accept:
  - If `cnt == R-1` or `in.last`, the word is complete:
    - The output register loads `acc | beat_at_slot(cnt)`.
    - `tlast` is set to `in.last`.
    - `tvalid` goes to 1.
    - The accumulator and `cnt` clear to 0.
  - Otherwise, merge the beat into the accumulator and increment `cnt`.
- Partial flush: on `last` with `cnt < R-1`, the unfilled upper slots carry tdata = 0 and tkeep = 0.
- R = 1 (64-bit mode): every accepted beat completes a word. This is plain registered passthrough: tdata = concatenated lanes, tkeep = each keep replicated x8.
- `in.ready = !out.tvalid || out.tready`. It is identical in every mode, and no accumulator-only bypass exists.
  - Consequence: a stalled output stalls accumulation.
- Output handshake: when `out.tvalid && out.tready` with no simultaneous completion, `tvalid` clears. With a simultaneous completion, the new word is loaded and `tvalid` stays 1.
- A `last` beat with all keep bits 0 is still emitted, as a word with tkeep = 0 and tlast = 1.
- Reset, including mid-word: `out.tvalid`, `tlast`, `tdata` and `tkeep` go to 0, and `cnt`, the accumulator and `sel_q` clear. A partially accumulated word is discarded. `in.ready` is 0 while `rst_n` is low.

## Timing
- Latency: the completing input beat accepted at edge N gives `out.tvalid` = 1 after edge N, with data on that cycle.
- Throughput: one input beat per cycle in all modes while `out.tready` = 1. Output rate is 1/R words per input beat, or 1 per beat at a last-flush.
- Outputs are driven only from registers. `in.ready` is combinational from `out.tready` and `out.tvalid`.
- AXI rules: `tvalid`, `tdata`, `tkeep` and `tlast` stay stable while `tvalid && !tready`. `tvalid` never depends on `tready`.
- No bubble is required between packets; the first beat of packet n+1 may be accepted on the cycle after the `last` of packet n.

## Test plan
Directed scenarios use `NUM_ELEMENTS` = 2 (AXI_WIDTH = 128).

- **32-bit packing.** `width_sel` = 2; beats {0x11, 0x22}, then {0x33, 0x44, last}.
  - Required: one word, tdata = 0x00000044_00000033_00000022_00000011, tkeep = 0xFFFF, tlast = 1, on the cycle after the second accept.
- **8-bit partial flush.** `width_sel` = 0; beats {0xA0, 0xA1}, {0xA2, 0xA3}, {0xA4, 0xA5, last}.
  - Required: tdata = 0x...00_A5A4A3A2A1A0 with upper bytes zero, tkeep = 0x003F, tlast = 1.
- **64-bit passthrough under backpressure.** `width_sel` = 3; 4 beats, with `tready` low for 3 cycles after beat 2.
  - Required: 4 words in order, tdata = {data[1], data[0]}, tkeep = 0xFFFF.
  - Required: `in.ready` = 0 during the stall, and outputs stable while stalled.
- **Sparse keep and width latch.** `width_sel` = 1; beat 0 with keep = 2'b01.
  - Toggle `width_sel` to 2 before beat 1, then send beats 1..3.
  - Required: 16-bit packing is kept for the whole word; tkeep bits [3:2] = 0.
  - Required: the next word uses 32-bit packing.
- **Reset mid-word.** `width_sel` = 0; 3 beats accepted, then `rst_n` low for 1 cycle, then 8 fresh beats.
  - Required: no stale bytes appear; the first output contains only the fresh beats, with tkeep = 0xFFFF.
- **Simultaneous drain and load.** `width_sel` = 3, `tready` held at 1, 16 back-to-back beats.
  - Required: `tvalid` stays 1 continuously and `in.ready` stays 1, giving 16 words in 16 cycles.

Source files
------------

// File: rtl/ndata_to_axi_packed.sv
// ndata_to_axi_packed: packs a NUM_ELEMENTS-wide stream of 8/16/32/64-bit
// elements (one element per 64-bit input lane) into a 64*NUM_ELEMENTS-bit
// AXI4-Stream word. R = 64/W input beats fill one word; a 'last' beat
// flushes a partial word with the unfilled slots zeroed.

// Per-lane placement: positions one input element (data and keep) at its
// slot inside the full-width output word for the current width and slot.
module ndata_to_axi_packed_lane #(
    parameter int NUM_ELEMENTS = 8,
    parameter int LANE         = 0
) (
    input  logic [1:0]                     sel,
    input  logic [2:0]                     slot,
    input  logic [63:0]                    data,
    input  logic                           keep,
    output logic [64*NUM_ELEMENTS-1:0]     pdata,
    output logic [8*NUM_ELEMENTS-1:0]      pkeep
);
    localparam int AXI_WIDTH = 64 * NUM_ELEMENTS;
    localparam int KW        = AXI_WIDTH / 8;

    logic [AXI_WIDTH-1:0] elem;
    logic [7:0]           kmask;
    logic [31:0]          pos;   // byte offset of this element in the word

    // Mask the element to W bits and shift it to slot*N*W + LANE*W.
    always_comb begin
        elem  = '0;
        kmask = '0;
        case (sel)
            2'd0: begin elem = AXI_WIDTH'(data[7:0]);  kmask = 8'h01; end
            2'd1: begin elem = AXI_WIDTH'(data[15:0]); kmask = 8'h03; end
            2'd2: begin elem = AXI_WIDTH'(data[31:0]); kmask = 8'h0F; end
            default: begin elem = AXI_WIDTH'(data);    kmask = 8'hFF; end
        endcase
        // element index within the word, scaled by W/8 bytes
        pos   = (32'(slot) * 32'(NUM_ELEMENTS) + 32'(LANE)) << sel;
        pdata = elem << {pos, 3'b000};
        pkeep = KW'(keep ? kmask : 8'h00) << pos;
    end
endmodule

module ndata_to_axi_packed #(
    parameter  int NUM_ELEMENTS = 8,
    localparam int AXI_WIDTH    = 64 * NUM_ELEMENTS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [1:0]                        width_sel,
    input  logic [NUM_ELEMENTS-1:0][63:0]     in_data,
    input  logic [NUM_ELEMENTS-1:0]           in_keep,
    input  logic                              in_last,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [AXI_WIDTH-1:0]              out_tdata,
    output logic [AXI_WIDTH/8-1:0]            out_tkeep,
    output logic                              out_tlast,
    output logic                              out_tvalid,
    input  logic                              out_tready
);
    localparam int KW = AXI_WIDTH / 8;

    logic [AXI_WIDTH-1:0] acc_data_q, acc_data_d;
    logic [KW-1:0]        acc_keep_q, acc_keep_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [1:0]           sel_q, sel_d;
    logic [AXI_WIDTH-1:0] tdata_q, tdata_d;
    logic [KW-1:0]        tkeep_q, tkeep_d;
    logic                 tlast_q, tlast_d;
    logic                 tvalid_q, tvalid_d;

    logic [1:0]           eff_sel;
    logic [2:0]           last_slot;
    logic                 accept;
    logic                 complete;

    logic [NUM_ELEMENTS-1:0][AXI_WIDTH-1:0] lane_data;
    logic [NUM_ELEMENTS-1:0][KW-1:0]        lane_keep;
    logic [AXI_WIDTH-1:0]                   beat_data;
    logic [KW-1:0]                          beat_keep;

    // Width for this beat: the live select opens a word, the latched one
    // holds for the rest of it so mid-word changes cannot corrupt packing.
    always_comb begin
        eff_sel = (cnt_q == 3'd0) ? width_sel : sel_q;
        case (eff_sel)
            2'd0:    last_slot = 3'd7;
            2'd1:    last_slot = 3'd3;
            2'd2:    last_slot = 3'd1;
            default: last_slot = 3'd0;
        endcase
    end

    for (genvar g = 0; g < NUM_ELEMENTS; g++) begin : g_lane
        ndata_to_axi_packed_lane #(
            .NUM_ELEMENTS (NUM_ELEMENTS),
            .LANE         (g)
        ) u_lane (
            .sel   (eff_sel),
            .slot  (cnt_q),
            .data  (in_data[g]),
            .keep  (in_keep[g]),
            .pdata (lane_data[g]),
            .pkeep (lane_keep[g])
        );
    end

    // Lanes occupy disjoint bit ranges, so OR merges them into one beat.
    always_comb begin
        beat_data = '0;
        beat_keep = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            beat_data = beat_data | lane_data[i];
            beat_keep = beat_keep | lane_keep[i];
        end
    end

    // Accumulation only advances when the output register can take a word,
    // so a stalled output also stalls accumulation.
    assign in_ready = rst_n && (!tvalid_q || out_tready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (cnt_q == last_slot));

    // Next state: merge beat into accumulator or emit the finished word;
    // a drain without a new word drops tvalid.
    always_comb begin
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;
        if (tvalid_q && out_tready) begin
            tvalid_d = 1'b0;
        end
        if (accept) begin
            if (cnt_q == 3'd0) begin
                sel_d = width_sel;
            end
            if (complete) begin
                // unfilled upper slots are still zero in the accumulator
                tdata_d    = acc_data_q | beat_data;
                tkeep_d    = acc_keep_q | beat_keep;
                tlast_d    = in_last;
                tvalid_d   = 1'b1;
                acc_data_d = '0;
                acc_keep_d = '0;
                cnt_d      = 3'd0;
            end else begin
                acc_data_d = acc_data_q | beat_data;
                acc_keep_d = acc_keep_q | beat_keep;
                cnt_d      = cnt_q + 3'd1;
            end
        end
    end

    // State registers; reset discards any partially built word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_data_q <= '0;
            acc_keep_q <= '0;
            cnt_q      <= '0;
            sel_q      <= '0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
        end else begin
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
        end
    end

    assign out_tdata  = tdata_q;
    assign out_tkeep  = tkeep_q;
    assign out_tlast  = tlast_q;
    assign out_tvalid = tvalid_q;
endmodule

// File: tb/tb_ndata_to_axi_packed.sv
// Bench for ndata_to_axi_packed with NUM_ELEMENTS = 2 (128-bit output):
// vector table, directed multi-cycle sequences, then random traffic scored
// against a word-level packing model.
module tb_ndata_to_axi_packed;
    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        width_sel;
    logic [1:0][63:0]  in_data;
    logic [1:0]        in_keep;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [127:0]      out_tdata;
    logic [15:0]       out_tkeep;
    logic              out_tlast;
    logic              out_tvalid;
    logic              out_tready;

    ndata_to_axi_packed #(.NUM_ELEMENTS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .width_sel  (width_sel),
        .in_data    (in_data),
        .in_keep    (in_keep),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_tdata  (out_tdata),
        .out_tkeep  (out_tkeep),
        .out_tlast  (out_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [1:0] k, input logic l);
        width_sel  = sel;
        in_data[0] = d0;
        in_data[1] = d1;
        in_keep    = k;
        in_last    = l;
        in_valid   = 1'b1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } word_t;
    word_t       exp_q[$];
    logic [63:0] m_d[8][2];
    logic        m_k[8][2];
    int          m_n = 0;
    logic [1:0]  m_sel = 2'd0;

    // Collect beats of a word; on R beats or last, lay element (beat b,
    // lane i) at element index b*2+i of width W and queue the word.
    task automatic model_accept(input logic [1:0] sel, input logic [1:0][63:0] d,
                                input logic [1:0] k, input logic l);
        word_t       w;
        int          wb, idx;
        logic [63:0] m;
        if (m_n == 0) m_sel = sel;
        m_d[m_n][0] = d[0];
        m_d[m_n][1] = d[1];
        m_k[m_n][0] = k[0];
        m_k[m_n][1] = k[1];
        m_n++;
        if (m_n == (8 >> m_sel) || l) begin
            wb  = 8 << m_sel;
            m   = (wb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << wb) - 64'd1);
            w.d = '0;
            w.k = '0;
            w.l = l;
            for (int b = 0; b < m_n; b++) begin
                for (int i = 0; i < 2; i++) begin
                    idx = b * 2 + i;
                    w.d = w.d | (128'(m_d[b][i] & m) << (idx * wb));
                    for (int y = 0; y < wb / 8; y++) w.k[idx * (wb / 8) + y] = m_k[b][i];
                end
            end
            exp_q.push_back(w);
            m_n = 0;
        end
    endtask

    logic         mon_en = 1'b0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_td;
    logic [15:0]  prev_tk;
    logic         prev_tl;
    int           words_seen = 0;

    // Scoreboard: sampled mid-cycle, records the handshakes of the next edge.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            word_t w;
            chk("ready_rule", 128'(in_ready), 128'(!out_tvalid || out_tready));
            if (prev_stall) begin
                chk("stall_tvalid", 128'(out_tvalid), 128'(1'b1));
                chk("stall_tdata", out_tdata, prev_td);
                chk("stall_tkeep", 128'(out_tkeep), 128'(prev_tk));
                chk("stall_tlast", 128'(out_tlast), 128'(prev_tl));
            end
            if (out_tvalid && out_tready) begin
                chk("sb_nonempty", 128'(exp_q.size() > 0), 128'(1'b1));
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    chk("rnd_tdata", out_tdata, w.d);
                    chk("rnd_tkeep", 128'(out_tkeep), 128'(w.k));
                    chk("rnd_tlast", 128'(out_tlast), 128'(w.l));
                    words_seen++;
                end
            end
            if (in_valid && in_ready) model_accept(width_sel, in_data, in_keep, in_last);
            prev_stall = out_tvalid && !out_tready;
            prev_td    = out_tdata;
            prev_tk    = out_tkeep;
            prev_tl    = out_tlast;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]   sel;
        logic [63:0]  d0, d1;
        logic [1:0]   keep;
        logic         last;
        logic         has;
        logic [127:0] td;
        logic [15:0]  tk;
        logic         tl;
    } vec_t;
    localparam int NV = 13;
    vec_t vt[NV];

    logic [63:0]  w0, w1, bd0, bd1;
    logic [127:0] exp_w;

    initial begin
        // 32-bit packing
        vt[0]  = '{2'd2, 64'h11, 64'h22, 2'b11, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
        vt[1]  = '{2'd2, 64'h33, 64'h44, 2'b11, 1'b1, 1'b1,
                   128'h00000044_00000033_00000022_00000011, 16'hFFFF, 1'b1};
        // 8-bit partial flush, upper lane bits are junk
        vt[2]  = '{2'd0, 64'hFFFFFFFF_FFFFFFA0, 64'hFFFFFFFF_FFFFFFA1, 2'b11, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
        vt[3]  = '{2'd0, 64'hFFFFFFFF_FFFFFFA2, 64'hFFFFFFFF_FFFFFFA3, 2'b11, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
        vt[4]  = '{2'd0, 64'hFFFFFFFF_FFFFFFA4, 64'hFFFFFFFF_FFFFFFA5, 2'b11, 1'b1, 1'b1,
                   128'hA5A4A3A2A1A0, 16'h003F, 1'b1};
        // sparse keep, width_sel changed mid-word is ignored
        vt[5]  = '{2'd1, 64'h1111, 64'h2222, 2'b01, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
        vt[6]  = '{2'd2, 64'h3333, 64'h4444, 2'b11, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
        vt[7]  = '{2'd2, 64'h5555, 64'h6666, 2'b11, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
        vt[8]  = '{2'd2, 64'h7777, 64'h8888, 2'b11, 1'b0, 1'b1,
                   128'h8888_7777_6666_5555_4444_3333_2222_1111, 16'hFFF3, 1'b0};
        // next word picks up 32-bit packing
        vt[9]  = '{2'd2, 64'h12345678_AAAAAAAA, 64'h9ABCDEF0_BBBBBBBB, 2'b11, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
        vt[10] = '{2'd2, 64'h0F0F0F0F_CCCCCCCC, 64'hF0F0F0F0_DDDDDDDD, 2'b11, 1'b0, 1'b1,
                   128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'hFFFF, 1'b0};
        // all-zero keep on last still emits
        vt[11] = '{2'd3, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 2'b00, 1'b1, 1'b1,
                   128'hFEDCBA9876543210_0123456789ABCDEF, 16'h0000, 1'b1};
        // 16-bit last on the first beat
        vt[12] = '{2'd1, 64'h1234_BEEF, 64'h5678_CAFE, 2'b10, 1'b1, 1'b1,
                   128'hCAFEBEEF, 16'h000C, 1'b1};

        rst_n = 1'b0; width_sel = 2'd0; in_data = '0; in_keep = '0;
        in_last = 1'b0; in_valid = 1'b0; out_tready = 1'b1;
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'(1'b0));
        tick();
        chk("rst_tvalid", 128'(out_tvalid), 128'(1'b0));
        chk("rst_tdata", out_tdata, 128'h0);
        chk("rst_tkeep", 128'(out_tkeep), 128'h0);
        chk("rst_tlast", 128'(out_tlast), 128'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 128'(in_ready), 128'(1'b1));

        for (int v = 0; v < NV; v++) begin
            drive(vt[v].sel, vt[v].d0, vt[v].d1, vt[v].keep, vt[v].last);
            tick();
            if (vt[v].has) begin
                chk($sformatf("vec%0d_tvalid", v), 128'(out_tvalid), 128'(1'b1));
                chk($sformatf("vec%0d_tdata", v), out_tdata, vt[v].td);
                chk($sformatf("vec%0d_tkeep", v), 128'(out_tkeep), 128'(vt[v].tk));
                chk($sformatf("vec%0d_tlast", v), 128'(out_tlast), 128'(vt[v].tl));
            end else begin
                chk($sformatf("vec%0d_idle", v), 128'(out_tvalid), 128'(1'b0));
            end
        end
        in_valid = 1'b0;
        tick();
        tick();

        // 64-bit passthrough with a 3-cycle output stall after beat 2
        drive(2'd3, 64'hA0A0_0000_0000_0001, 64'hA1A1_0000_0000_0001, 2'b11, 1'b0);
        tick();
        chk("bp_w0", out_tdata, {64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0001});
        chk("bp_w0_keep", 128'(out_tkeep), 128'hFFFF);
        drive(2'd3, 64'hB0B0_0000_0000_0002, 64'hB1B1_0000_0000_0002, 2'b11, 1'b0);
        tick();
        chk("bp_w1", out_tdata, {64'hB1B1_0000_0000_0002, 64'hB0B0_0000_0000_0002});
        out_tready = 1'b0;
        drive(2'd3, 64'hC0C0_0000_0000_0003, 64'hC1C1_0000_0000_0003, 2'b11, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_stall_ready", 128'(in_ready), 128'(1'b0));
            tick();
            chk("bp_stall_tvalid", 128'(out_tvalid), 128'(1'b1));
            chk("bp_stall_tdata", out_tdata, {64'hB1B1_0000_0000_0002, 64'hB0B0_0000_0000_0002});
        end
        out_tready = 1'b1;
        #1;
        chk("bp_resume_ready", 128'(in_ready), 128'(1'b1));
        tick();
        chk("bp_w2", out_tdata, {64'hC1C1_0000_0000_0003, 64'hC0C0_0000_0000_0003});
        drive(2'd3, 64'hD0D0_0000_0000_0004, 64'hD1D1_0000_0000_0004, 2'b11, 1'b0);
        tick();
        chk("bp_w3", out_tdata, {64'hD1D1_0000_0000_0004, 64'hD0D0_0000_0000_0004});
        chk("bp_w3_keep", 128'(out_tkeep), 128'hFFFF);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", 128'(out_tvalid), 128'(1'b0));

        // reset in the middle of an 8-bit word
        for (int j = 0; j < 3; j++) begin
            drive(2'd0, 64'hEE, 64'hEE, 2'b11, 1'b0);
            tick();
        end
        chk("rw_partial_idle", 128'(out_tvalid), 128'(1'b0));
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rw_rst_ready", 128'(in_ready), 128'(1'b0));
        tick();
        chk("rw_rst_tdata", out_tdata, 128'h0);
        rst_n = 1'b1;
        exp_w = '0;
        for (int j = 0; j < 8; j++) begin
            drive(2'd0, 64'(8'h10 + 8'(2 * j)), 64'(8'h11 + 8'(2 * j)), 2'b11, 1'b0);
            exp_w[(2 * j) * 8 +: 8]     = 8'h10 + 8'(2 * j);
            exp_w[(2 * j + 1) * 8 +: 8] = 8'h11 + 8'(2 * j);
            tick();
            if (j < 7) chk("rw_fresh_idle", 128'(out_tvalid), 128'(1'b0));
        end
        chk("rw_tvalid", 128'(out_tvalid), 128'(1'b1));
        chk("rw_tdata", out_tdata, exp_w);
        chk("rw_tkeep", 128'(out_tkeep), 128'hFFFF);
        in_valid = 1'b0;
        tick();

        // back-to-back 64-bit beats: one word per cycle
        for (int j = 0; j < 16; j++) begin
            bd0 = {$urandom, $urandom};
            bd1 = {$urandom, $urandom};
            drive(2'd3, bd0, bd1, 2'b11, 1'b0);
            #1;
            chk("b2b_ready", 128'(in_ready), 128'(1'b1));
            tick();
            chk("b2b_tvalid", 128'(out_tvalid), 128'(1'b1));
            chk("b2b_tdata", out_tdata, {bd1, bd0});
        end
        in_valid = 1'b0;
        tick();
        tick();

        // random traffic against the model
        mon_en = 1'b1;
        width_sel = 2'($urandom_range(0, 3));
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) width_sel = 2'($urandom_range(0, 3));
            w0 = {$urandom, $urandom};
            w1 = {$urandom, $urandom};
            in_data[0] = w0;
            in_data[1] = w1;
            in_keep    = 2'($urandom_range(0, 3));
            in_last    = ($urandom_range(0, 7) == 0);
            in_valid   = ($urandom_range(0, 9) < 7);
            out_tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid   = 1'b0;
        out_tready = 1'b1;
        repeat (20) tick();
        chk("sb_drained", 128'(exp_q.size()), 128'h0);
        chk("sb_activity", 128'(words_seen > 50), 128'(1'b1));
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
